// File: rtl/spi_link_pkg.sv
// Shared types, status field map and helpers for the SPI link scheduler.
package spi_link_pkg;

    typedef enum logic [3:0] {
        A_ANGLE  = 4'd2,
        A_PERIOD = 4'd3,
        A_MODE   = 4'd4,
        A_CMD    = 4'd5,
        A_POWER  = 4'd6,
        A_READ   = 4'd15
    } addr_t;

    typedef enum logic [1:0] {IDLE, SNAP, LOAD, WAIT} tx_state_t;

    localparam int unsigned POWER_BIT = 31;
    localparam int unsigned CMD_HI    = 30;
    localparam int unsigned CMD_LO    = 29;
    localparam int unsigned MODE_HI   = 28;
    localparam int unsigned MODE_LO   = 27;
    localparam int unsigned PERIOD_HI = 19;
    localparam int unsigned PERIOD_LO = 12;
    localparam int unsigned ANGLE_HI  = 11;
    localparam int unsigned ANGLE_LO  = 0;

    // Reserved bits 26:20 are never reported, so they are not kept in the snapshot.
    localparam logic [31:0] STATUS_USED = 32'hF80F_FFFF;

    function automatic logic is_cmd_addr(input logic [3:0] addr);
        return (addr >= 4'd2) && (addr <= 4'd6);
    endfunction

    function automatic logic [11:0] field_of(input logic [3:0] addr, input logic [31:0] snapshot);
        logic [11:0] field;
        field = '0;
        case (addr)
            A_ANGLE:  field = snapshot[ANGLE_HI:ANGLE_LO];
            A_PERIOD: field = {4'd0, snapshot[PERIOD_HI:PERIOD_LO]};
            A_MODE:   field = {10'd0, snapshot[MODE_HI:MODE_LO]};
            A_CMD:    field = {10'd0, snapshot[CMD_HI:CMD_LO]};
            A_POWER:  field = {11'd0, snapshot[POWER_BIT]};
            default:  field = '0;
        endcase
        return field;
    endfunction

endpackage

// File: rtl/spi_rx_commit.sv
// Captures host command words, issues the one-cycle commit to interface_controller and
// flags malformed or overrunning words.
module spi_rx_commit
    import spi_link_pkg::*;
(
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] rx_word,
    input  logic        rx_valid,
    output logic [15:0] spi_word,
    output logic        readBusy,
    output logic        frame_err,
    output logic        rdReqValid,
    output logic [3:0]  rdReqAddr
);

    logic [3:0] rxAddr;
    logic       commitQ;
    logic       inFlight;
    logic       isWrite;
    logic       isRead;
    logic       accept;
    logic       commitD;
    logic       frameErrD;

    assign rxAddr    = rx_word[15:12];
    assign rdReqAddr = rx_word[3:0];

    // A commit owns the two cycles after its strobe; any word landing there is an overrun.
    assign inFlight = commitQ || !readBusy;

    always_comb begin
        isWrite    = is_cmd_addr(rxAddr);
        isRead     = (rxAddr == A_READ) && is_cmd_addr(rdReqAddr);
        accept     = rx_valid && !inFlight;
        commitD    = accept && isWrite;
        rdReqValid = accept && isRead;
        frameErrD  = rx_valid && (inFlight || !(isWrite || isRead));
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            spi_word  <= '0;
            commitQ   <= 1'b0;
            readBusy  <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            if (commitD) begin
                spi_word <= rx_word;
            end
            commitQ   <= commitD;
            readBusy  <= !commitQ;
            frame_err <= frameErrD;
        end
    end

endmodule

// File: rtl/spi_link_scheduler.sv
// FPGA-side SPI link sequencer: host command commit path plus round-robin telemetry
// frames, with host read requests preempting the rotation.
module spi_link_scheduler
    import spi_link_pkg::*;
#(
    parameter int unsigned TX_PERIOD = 1000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] rx_word,
    input  logic        rx_valid,
    input  logic [31:0] status_reg,
    input  logic        tx_ready,
    output logic [15:0] spi_word,
    output logic        readBusy,
    output logic        writeBusy,
    output logic [15:0] tx_word,
    output logic        tx_valid,
    output logic        frame_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_PERIOD - 1);

    tx_state_t        stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [3:0]       rrPtrQ, rrPtrD;
    logic [3:0]       pendAddrQ, pendAddrD;
    logic             pendValidQ, pendValidD;
    logic [31:0]      snapQ, snapD;
    logic [15:0]      txWordQ, txWordD;
    logic             txValidQ, txValidD;
    logic [3:0]       loadAddr;
    logic             rdReqValid;
    logic [3:0]       rdReqAddr;

    spi_rx_commit u_rx_commit (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .rx_word    (rx_word),
        .rx_valid   (rx_valid),
        .spi_word   (spi_word),
        .readBusy   (readBusy),
        .frame_err  (frame_err),
        .rdReqValid (rdReqValid),
        .rdReqAddr  (rdReqAddr)
    );

    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        rrPtrD     = rrPtrQ;
        pendAddrD  = pendAddrQ;
        pendValidD = pendValidQ;
        snapD      = snapQ;
        txWordD    = txWordQ;
        txValidD   = txValidQ;
        loadAddr   = pendValidQ ? pendAddrQ : rrPtrQ;

        case (stateQ)
            IDLE: begin
                cntD = cntQ + 1'b1;
                if (pendValidQ || (cntQ == CNT_LAST)) begin
                    stateD = SNAP;
                end
            end
            SNAP: begin
                snapD  = status_reg & STATUS_USED;
                stateD = LOAD;
            end
            LOAD: begin
                txWordD  = {loadAddr, field_of(loadAddr, snapQ)};
                txValidD = 1'b1;
                if (pendValidQ) begin
                    pendValidD = 1'b0;
                end else begin
                    rrPtrD = (rrPtrQ == A_POWER) ? A_ANGLE : rrPtrQ + 4'd1;
                end
                stateD = WAIT;
            end
            WAIT: begin
                if (tx_ready) begin
                    txValidD = 1'b0;
                    cntD     = '0;
                    stateD   = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase

        // Single-entry read queue: the newest host request always wins.
        if (rdReqValid) begin
            pendValidD = 1'b1;
            pendAddrD  = rdReqAddr;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            stateQ     <= IDLE;
            cntQ       <= '0;
            rrPtrQ     <= A_ANGLE;
            pendAddrQ  <= '0;
            pendValidQ <= 1'b0;
            snapQ      <= '0;
            txWordQ    <= '0;
            txValidQ   <= 1'b0;
        end else begin
            stateQ     <= stateD;
            cntQ       <= cntD;
            rrPtrQ     <= rrPtrD;
            pendAddrQ  <= pendAddrD;
            pendValidQ <= pendValidD;
            snapQ      <= snapD;
            txWordQ    <= txWordD;
            txValidQ   <= txValidD;
        end
    end

    assign writeBusy = (stateQ != SNAP);
    assign tx_word   = txWordQ;
    assign tx_valid  = txValidQ;

endmodule

// File: tb/tb_spi_link_scheduler.sv
// Randomised scoreboard bench for spi_link_scheduler against a frame/commit-level model.
module tb_spi_link_scheduler;

    localparam int unsigned TX_PERIOD = 16;
    localparam int unsigned CNT_W     = 8;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic [15:0] rx_word = '0;
    logic        rx_valid = 1'b0;
    logic [31:0] status_reg = '0;
    logic        tx_ready = 1'b1;
    logic [15:0] spi_word;
    logic        readBusy;
    logic        writeBusy;
    logic [15:0] tx_word;
    logic        tx_valid;
    logic        frame_err;

    spi_link_scheduler #(
        .TX_PERIOD (TX_PERIOD),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .rx_word    (rx_word),
        .rx_valid   (rx_valid),
        .status_reg (status_reg),
        .tx_ready   (tx_ready),
        .spi_word   (spi_word),
        .readBusy   (readBusy),
        .writeBusy  (writeBusy),
        .tx_word    (tx_word),
        .tx_valid   (tx_valid),
        .frame_err  (frame_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] w;
        int          c;
    } commit_t;

    int          nChecks = 0;
    int          nFails = 0;
    int          hsCount = 0;
    int          readyMode = 0;
    int          rrModel = 2;
    int          busyUntil = -100;
    commit_t     commitExp[$];
    int          errExp[$];
    logic [15:0] txExp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        nChecks++;
        nFails++;
        $display("FAIL %s: actual event state differs from required (cycle %0d)", name, cyc);
    endtask

    function automatic logic [11:0] exp_field(input int a, input logic [31:0] st);
        case (a)
            2:       return 12'(st & 32'hFFF);
            3:       return 12'((st >> 12) & 32'hFF);
            4:       return 12'((st >> 27) & 32'h3);
            5:       return 12'((st >> 29) & 32'h3);
            6:       return 12'(st >> 31);
            default: return 12'd0;
        endcase
    endfunction

    function automatic logic [15:0] next_rot();
        logic [15:0] f;
        f = {4'(rrModel), exp_field(rrModel, status_reg)};
        rrModel = (rrModel == 6) ? 2 : rrModel + 1;
        return f;
    endfunction

    // Word-level model: writes commit two cycles on and block the link until then.
    function automatic void rx_model(input logic [15:0] w, input int s);
        int      a;
        int      t;
        commit_t c;
        a = int'(w[15:12]);
        t = int'(w[3:0]);
        if (s <= busyUntil) begin
            errExp.push_back(s + 1);
        end else if (a >= 2 && a <= 6) begin
            c.w = w;
            c.c = s + 2;
            commitExp.push_back(c);
            busyUntil = s + 2;
        end else if (!(a == 15 && t >= 2 && t <= 6)) begin
            errExp.push_back(s + 1);
        end
    endfunction

    task automatic rx_cycle(input logic v, input logic [15:0] w);
        @(posedge CLK);
        #1;
        rx_valid = v;
        rx_word  = w;
        if (v) rx_model(w, cyc);
    endtask

    task automatic wait_hs(input int target, input string name);
        int n;
        n = 0;
        while (hsCount < target && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (hsCount < target) fail(name);
    endtask

    task automatic sync_frame();
        wait_hs(hsCount + 1, "frame handshake timeout");
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!tx_valid && n < 200);
        if (!tx_valid) fail(name);
    endtask

    initial begin : ready_driver
        forever begin
            @(posedge CLK);
            #1;
            case (readyMode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom % 2);
                default: tx_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        logic        prevStall;
        logic        prevValid;
        logic [15:0] prevWord;
        logic [15:0] e;
        int          snapCyc;
        int          ec;
        commit_t     c;
        prevStall = 1'b0;
        prevValid = 1'b0;
        prevWord  = '0;
        snapCyc   = -100;
        forever begin
            @(negedge CLK);
            if (!nRESET) begin
                prevStall = 1'b0;
                prevValid = 1'b0;
            end else begin
                if (prevStall) begin
                    check("tx_valid held", 32'(tx_valid), 32'd1);
                    check("tx_word held", 32'(tx_word), 32'(prevWord));
                end
                if (!writeBusy) snapCyc = cyc;
                if (tx_valid && !prevValid) check("snapshot to tx_valid", 32'(cyc), 32'(snapCyc + 2));
                if (tx_valid && tx_ready) begin
                    e = (txExp.size() > 0) ? txExp.pop_front() : next_rot();
                    check("tx frame", 32'(tx_word), 32'(e));
                    hsCount++;
                end
                if (commitExp.size() > 0 && commitExp[0].c == cyc + 1)
                    check("spi_word at N+1", 32'(spi_word), 32'(commitExp[0].w));
                if (!readBusy) begin
                    if (commitExp.size() == 0) begin
                        fail("unexpected commit");
                    end else begin
                        c = commitExp.pop_front();
                        check("commit word", 32'(spi_word), 32'(c.w));
                        check("commit cycle", 32'(cyc), 32'(c.c));
                    end
                end
                if (frame_err) begin
                    if (errExp.size() == 0) begin
                        fail("unexpected frame_err");
                    end else begin
                        ec = errExp.pop_front();
                        check("frame_err cycle", 32'(cyc), 32'(ec));
                    end
                end
                prevStall = tx_valid && !tx_ready;
                prevValid = tx_valid;
                prevWord  = tx_word;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          rel;
        int          h0;
        int          t;
        int          t2;
        int          a;
        int          gap;
        logic [15:0] w;

        status_reg = 32'h0000_0343;
        repeat (3) @(posedge CLK);
        #1;
        check("reset readBusy", 32'(readBusy), 32'd1);
        check("reset writeBusy", 32'(writeBusy), 32'd1);
        check("reset tx_valid", 32'(tx_valid), 32'd0);
        check("reset tx_word", 32'(tx_word), 32'd0);
        check("reset spi_word", 32'(spi_word), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);

        @(posedge CLK);
        #1;
        nRESET = 1'b1;
        rel = cyc;
        wait_valid("first frame timeout");
        check("first frame cycle", 32'(cyc), 32'(rel + int'(TX_PERIOD) + 2));
        check("first frame word", 32'(tx_word), 32'h2343);
        wait_hs(1, "first frame handshake");

        // Single command commit.
        rx_cycle(1'b1, 16'h3343);
        repeat (4) rx_cycle(1'b0, 16'h0);

        // Host read preempts rotation.
        sync_frame();
        status_reg = 32'h8000_0343;
        h0 = hsCount;
        txExp.push_back(16'h6001);
        rx_cycle(1'b1, 16'hF006);
        rx_cycle(1'b0, 16'h0);
        wait_hs(h0 + 2, "read frame then rotation");

        for (int i = 0; i < 4; i++) begin
            sync_frame();
            status_reg = $urandom;
            t = $urandom_range(2, 6);
            h0 = hsCount;
            txExp.push_back({4'(t), exp_field(t, status_reg)});
            rx_cycle(1'b1, {4'hF, 8'($urandom), 4'(t)});
            rx_cycle(1'b0, 16'h0);
            wait_hs(h0 + 2, "random read frame");
        end

        // Back-to-back reads: the second overwrites the first.
        sync_frame();
        status_reg = $urandom;
        t = $urandom_range(2, 6);
        t2 = $urandom_range(2, 6);
        h0 = hsCount;
        txExp.push_back({4'(t2), exp_field(t2, status_reg)});
        rx_cycle(1'b1, {12'hF00, 4'(t)});
        rx_cycle(1'b1, {12'hF00, 4'(t2)});
        rx_cycle(1'b0, 16'h0);
        wait_hs(h0 + 2, "overwritten read");

        // Read arriving while a frame is stalled in WAIT is served right after it.
        sync_frame();
        status_reg = $urandom;
        readyMode = 2;
        t = $urandom_range(2, 6);
        h0 = hsCount;
        txExp.push_back(next_rot());
        txExp.push_back({4'(t), exp_field(t, status_reg)});
        wait_valid("stalled frame timeout");
        rx_cycle(1'b1, {12'hF00, 4'(t)});
        repeat (20) rx_cycle(1'b0, 16'h0);
        readyMode = 0;
        wait_hs(h0 + 2, "queued read after stall");

        // Rotation wrap under random backpressure.
        readyMode = 1;
        h0 = hsCount;
        wait_hs(h0 + 6, "rotation wrap");

        // Directed bad words and overrun, then random RX traffic.
        rx_cycle(1'b1, 16'h1123);
        rx_cycle(1'b0, 16'h0);
        rx_cycle(1'b1, 16'hF009);
        rx_cycle(1'b0, 16'h0);
        rx_cycle(1'b1, 16'h2111);
        rx_cycle(1'b1, 16'h4222);
        repeat (3) rx_cycle(1'b0, 16'h0);
        for (int i = 0; i < 60; i++) begin
            case ($urandom % 4)
                0, 1: w = {4'($urandom_range(2, 6)), 12'($urandom)};
                2: begin
                    do a = $urandom % 16; while ((a >= 2 && a <= 6) || a == 15);
                    w = {4'(a), 12'($urandom)};
                end
                default: begin
                    do a = $urandom % 16; while (a >= 2 && a <= 6);
                    w = {4'hF, 8'($urandom), 4'(a)};
                end
            endcase
            rx_cycle(1'b1, w);
            gap = $urandom % 3;
            repeat (gap) rx_cycle(1'b0, 16'h0);
        end
        repeat (4) rx_cycle(1'b0, 16'h0);
        readyMode = 0;

        // Reset mid-frame: tx_valid drops asynchronously and the frame is not replayed.
        sync_frame();
        readyMode = 2;
        wait_valid("pre-reset frame timeout");
        @(negedge CLK);
        #2;
        nRESET = 1'b0;
        #1;
        check("async tx_valid clear", 32'(tx_valid), 32'd0);
        check("reset writeBusy mid-frame", 32'(writeBusy), 32'd1);
        txExp.delete();
        rrModel = 2;
        status_reg = $urandom;
        repeat (3) @(posedge CLK);
        #1;
        nRESET = 1'b1;
        rel = cyc;
        readyMode = 0;
        wait_valid("post-reset frame timeout");
        check("post-reset frame cycle", 32'(cyc), 32'(rel + int'(TX_PERIOD) + 2));
        check("post-reset frame word", 32'(tx_word), 32'({4'h2, exp_field(2, status_reg)}));
        h0 = hsCount;
        wait_hs(h0 + 2, "post-reset rotation");

        repeat (10) @(negedge CLK);
        check("commit queue drained", 32'(commitExp.size()), 32'd0);
        check("frame_err queue drained", 32'(errExp.size()), 32'd0);
        check("tx queue drained", 32'(txExp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
